gate_vector_sequencer: RTL

//   Sequential stimulus/check stage directly upstream of the two-input gate cells (Buf..Xnor).

---
 rtl/gate_vector_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/gate_vector_sequencer.sv
// Steps a packed {i1,i2} vector pattern onto the shared gate inputs and checks the eight
// gate outputs against their truth table, accumulating an error count and per-gate mask.
module gate_vector_sequencer #(
  parameter int                     NUM_VEC     = 4,
  parameter logic [2*NUM_VEC-1:0]   PATTERN     = 8'b00011011,
  parameter int                     HOLD_CYCLES = 5,
  parameter int                     CNT_W       = 8,
  localparam int                    VI_W        = $clog2(NUM_VEC) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       gate_out,
  output logic             i1,
  output logic             i2,
  output logic [VI_W-1:0]  vec_idx,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       err_mask
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic            hold_last;
  logic            launch;
  logic [7:0]      expected;
  logic [7:0]      mismatch;

  function automatic logic [1:0] vec_at(input logic [VI_W-1:0] idx);
    vec_at = PATTERN[2*idx +: 2];
  endfunction

  assign hold_last = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
  assign launch    = start && (state == IDLE || state == DONE);

  // Bit order matches the cell bundle: {xnor,xor,nand,nor,or,and,not,buf}.
  always_comb begin
    expected = {~(i1 ^ i2), i1 ^ i2, ~(i1 & i2), ~(i1 | i2), i1 | i2, i1 & i2, ~i1, i1};
  end

  // Case-inequality so an undriven or X cell output counts as a failure in simulation.
  always_comb begin
    mismatch = '0;
    for (int b = 0; b < 8; b++) begin
      mismatch[b] = (gate_out[b] !== expected[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (hold_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec_idx != '0) ? APPLY : DONE;
      DONE:    if (start) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == APPLY) || (state == SAMPLE);
    done         = (state == DONE);
    sample_valid = (state == SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1        <= 1'b0;
      i2        <= 1'b0;
      vec_idx   <= '0;
      hold_cnt  <= '0;
      err_count <= '0;
      err_mask  <= '0;
    end else if (launch) begin
      {i1, i2}  <= vec_at(VI_W'(NUM_VEC - 1));
      vec_idx   <= VI_W'(NUM_VEC - 1);
      hold_cnt  <= '0;
      err_count <= '0;
      err_mask  <= '0;
    end else begin
      case (state)
        APPLY: begin
          if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
        end
        SAMPLE: begin
          err_mask <= err_mask | mismatch;
          if ((mismatch != '0) && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
          end
          // Next vector is loaded on the same edge that leaves SAMPLE.
          if (vec_idx != '0) begin
            vec_idx  <= vec_idx - 1'b1;
            {i1, i2} <= vec_at(vec_idx - 1'b1);
            hold_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
